// File: rtl/nibble_serial_alu_sequencer.sv
// nibble_serial_alu_sequencer
//   Multi-cycle add/subtract engine. A single 4-bit carry-lookahead slice
//   is reused for WIDTH/4 cycles, least-significant nibble first. The
//   operation is requested with a start/ready handshake and completes with
//   a one-cycle done pulse. Outputs stay valid after done.
//
//   Optional build macro: NSA_ABORT_EN adds an 'abort' input. Asserting it
//   during RUN drops the operation. No done pulse is produced, result keeps
//   its partial value, and the flags keep their previous values.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous reset, active low
//   abort      in   1      (NSA_ABORT_EN only) cancel the operation in flight
//   start      in   1      request; accepted only while ready=1
//   sub        in   1      0: a+b, 1: a-b (sampled with start)
//   a, b       in   WIDTH  operands (sampled with start)
//   ready      out  1      engine idle, can accept start
//   busy       out  1      nibble iteration in progress
//   done       out  1      one-cycle completion pulse
//   result     out  WIDTH  sum / difference (modulo 2^WIDTH)
//   carry_out  out  1      carry out of MSB (sub: 1 = no borrow)
//   overflow   out  1      signed overflow
//   zero       out  1      result == 0
module nibble_serial_alu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef NSA_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CNT_W   = $clog2(NIBBLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    // Operands are shifted right one nibble per cycle, so the slice always
    // reads bits [3:0]. This avoids a wide read multiplexer.
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;

    logic             abort_req;
    logic             last_nib;
    logic [3:0]       p;
    logic [3:0]       g;
    logic [4:0]       c;
    logic [3:0]       sum;
    logic [WIDTH-1:0] res_next;

`ifdef NSA_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign ready    = (state == S_IDLE);
    assign busy     = (state == S_RUN);
    assign done     = (state == S_DONE);
    assign last_nib = (cnt == CNT_W'(NIBBLES - 1));

    // 4-bit carry-lookahead slice. c[4] is the group carry G | P&cin.
    // c[3] is kept because, on the top nibble, c[4]^c[3] gives signed overflow.
    // NOTE: every always_comb output is assigned a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        p      = a_sh[3:0] ^ b_sh[3:0];
        g      = a_sh[3:0] & b_sh[3:0];
        c[0]   = carry;
        c[1]   = g[0] | (p[0] & carry);
        c[2]   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
        c[3]   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & carry);
        c[4]   = (g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]))
               | ((&p) & carry);
        sum    = p ^ c[3:0];
        res_next = result;
        res_next[{cnt, 2'b00} +: 4] = sum;
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    // All registers in this block are cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            carry     <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert b here and seed the carry.
                        a_sh  <= a;
                        b_sh  <= b ^ {WIDTH{sub}};
                        carry <= sub;
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort_req) begin
                        // Keep the partial result and the previous flags.
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        result <= res_next;
                        carry  <= c[4];
                        a_sh   <= a_sh >> 4;
                        b_sh   <= b_sh >> 4;
                        if (last_nib) begin
                            carry_out <= c[4];
                            overflow  <= c[4] ^ c[3];
                            zero      <= ~|res_next;
                            cnt       <= '0;
                            state     <= S_DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_alu_sequencer.sv
// Directed testbench for nibble_serial_alu_sequencer (WIDTH=32).
// Expected values are hand-computed constants.
// When NSA_ABORT_EN is defined, the abort scenario is also exercised.
module tb_nibble_serial_alu_sequencer;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
`ifdef NSA_ABORT_EN
    logic             abort;
`endif
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    int checks;
    int failures;
    int lat;

    nibble_serial_alu_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef NSA_ABORT_EN
        .abort     (abort),
`endif
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Issue one operation at #1 after a rising edge, then count edges until
    // done is high. The accepting edge counts as edge 1.
    // The count is 0 if done never appears within the budget.
    task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                          input logic op_sub, output int latency);
        latency = 0;
        a     = op_a;
        b     = op_b;
        sub   = op_sub;
        start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                latency = k;
                break;
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        sub      = 1'b0;
        a        = '0;
        b        = '0;
`ifdef NSA_ABORT_EN
        abort    = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_flags", {carry_out, overflow, zero}, 3'b000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: 5 + 3
        run_op(32'h0000_0005, 32'h0000_0003, 1'b0, lat);
        check("t1_latency", lat, 9);
        check("t1_result", result, 32'h0000_0008);
        check("t1_flags", {carry_out, overflow, zero}, 3'b000);
        @(posedge clk);
        #1;
        check("t1_done_one_cycle", done, 0);
        check("t1_ready_after", ready, 1);
        check("t1_result_held", result, 32'h0000_0008);

        // 2: all-ones + 1 wraps to zero
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
        check("t2_latency", lat, 9);
        check("t2_result", result, 32'h0000_0000);
        check("t2_flags", {carry_out, overflow, zero}, 3'b101);
        @(posedge clk);
        #1;

        // 3: positive signed overflow
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
        check("t3_result", result, 32'h8000_0000);
        check("t3_flags", {carry_out, overflow, zero}, 3'b010);
        @(posedge clk);
        #1;

        // 4a: 3 - 5 borrows
        run_op(32'h0000_0003, 32'h0000_0005, 1'b1, lat);
        check("t4a_latency", lat, 9);
        check("t4a_result", result, 32'hFFFF_FFFE);
        check("t4a_flags", {carry_out, overflow, zero}, 3'b000);
        @(posedge clk);
        #1;

        // 4b: x - x = 0, no borrow
        run_op(32'h1234_5678, 32'h1234_5678, 1'b1, lat);
        check("t4b_result", result, 32'h0000_0000);
        check("t4b_flags", {carry_out, overflow, zero}, 3'b101);
        @(posedge clk);
        #1;

        // 4c: most-negative minus one overflows to positive
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, lat);
        check("t4c_result", result, 32'h7FFF_FFFF);
        check("t4c_flags", {carry_out, overflow, zero}, 3'b110);

        // start held through the DONE cycle must be ignored
        start = 1'b1;
        a     = 32'h0000_0001;
        b     = 32'h0000_0001;
        sub   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done_start_ignored_ready", ready, 1);
        check("done_start_ignored_busy", busy, 0);
        check("done_start_result_held", result, 32'h7FFF_FFFF);

        // 5a: start pulsed during RUN with new operands is ignored
        a     = 32'h0000_0010;
        b     = 32'h0000_0020;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("t5_busy", busy, 1);
        check("t5_ready_low", ready, 0);
        @(posedge clk);
        #1;
        a     = 32'h0000_FFFF;
        b     = 32'h0000_1111;
        sub   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        for (int k = 3; k <= 20; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("t5_latency", lat, 9);
        check("t5_result", result, 32'h0000_0030);
        check("t5_flags", {carry_out, overflow, zero}, 3'b000);
        @(posedge clk);
        #1;

        // 5b: reset asserted in RUN cycle 4
        a     = 32'hDEAD_BEEF;
        b     = 32'h1111_1111;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_ready", ready, 1);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_result", result, 0);
        check("t5_rst_flags", {carry_out, overflow, zero}, 3'b000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(32'h0000_0100, 32'h0000_0023, 1'b0, lat);
        check("t5_post_rst_latency", lat, 9);
        check("t5_post_rst_result", result, 32'h0000_0123);

`ifdef NSA_ABORT_EN
        // 6: abort during RUN cycle 3
        @(posedge clk);
        #1;
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
        check("t6_prev_flags", {carry_out, overflow, zero}, 3'b010);
        @(posedge clk);
        #1;
        a     = 32'h0000_0001;
        b     = 32'hFFFF_FFFF;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("t6_abort_ready", ready, 1);
        check("t6_abort_busy", busy, 0);
        check("t6_abort_done", done, 0);
        check("t6_abort_flags", {carry_out, overflow, zero}, 3'b010);
        repeat (12) begin
            @(posedge clk);
            #1;
            check("t6_no_done", done, 0);
        end
        run_op(32'h0000_0009, 32'h0000_0004, 1'b1, lat);
        check("t6_next_latency", lat, 9);
        check("t6_next_result", result, 32'h0000_0005);
        check("t6_next_flags", {carry_out, overflow, zero}, 3'b100);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
